// File: rtl/mul_div_unit_if.sv
// Handshake and HI/LO bus between the control/ALU side and the multiply/divide unit.
// Master issues start/op/operands and MTHI/MTLO writes; slave returns busy/done/HI/LO.
// WIDTH must match the mul_div_unit instance it connects to.
interface mul_div_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_zero;

  modport master (
    output start, op, a, b, hi_we, lo_we, wdata,
    input  busy, done, hi, lo, div_zero
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wdata,
    output busy, done, hi, lo, div_zero
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; shift-add multiply, restoring divide.
// Latency: WIDTH+1 cycles from the accepting edge to the done pulse, data independent.
// Backpressure: start is ignored while busy (no queueing); a start sampled on the done edge chains.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic   clk,
  input  logic   rst,
  mul_div_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               div_zero_q, div_zero_d;
  // Multiply: {partial product high, multiplier}. Divide: low half is dividend -> quotient.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  // Multiplicand (multiply) or divisor (divide), magnitude only.
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               is_div_q, is_div_d;
  logic               sa_q, sa_d;
  logic               sb_q, sb_d;
  logic               dz_pend_q, dz_pend_d;

  logic               op_signed, op_div, a_neg, b_neg, accept, q_bit;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH:0]     mul_addend, mul_sum, rem_sh, rem_diff;
  logic [2*WIDTH-1:0] prod_res;
  logic [WIDTH-1:0]   quo_res, rem_res;

  // Operand decode: only meaningful on the accepting edge.
  assign op_signed = ~bus.op[0];
  assign op_div    = bus.op[1];
  assign a_neg     = op_signed & bus.a[WIDTH-1];
  assign b_neg     = op_signed & bus.b[WIDTH-1];
  assign a_abs     = a_neg ? -bus.a : bus.a;
  assign b_abs     = b_neg ? -bus.b : bus.b;
  // FINISH also accepts so a new op can be chained on the done edge.
  assign accept    = bus.start & ((state_q == IDLE) | (state_q == FINISH));

  // One multiply step: conditionally add multiplicand to the high half, then shift right.
  assign mul_addend = acc_q[0] ? {1'b0, opnd_q} : '0;
  assign mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + mul_addend;

  // One restoring-divide step; the trial remainder needs WIDTH+1 bits, the kept one fits WIDTH.
  assign rem_sh   = {rem_q, acc_q[WIDTH-1]};
  assign rem_diff = rem_sh - {1'b0, opnd_q};
  assign q_bit    = ~rem_diff[WIDTH];

  // Sign fix-up. A zero divisor leaves the dividend magnitude as remainder, so the normal
  // remainder negation already restores the original a for HI.
  assign prod_res = (sa_q ^ sb_q) ? -acc_q : acc_q;
  assign quo_res  = dz_pend_q ? '1 :
                    ((sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
  assign rem_res  = sa_q ? -rem_q : rem_q;

  // Next-state logic for the FSM, datapath and HI/LO.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    hi_d       = hi_q;
    lo_d       = lo_q;
    div_zero_d = div_zero_q;
    acc_d      = acc_q;
    rem_d      = rem_q;
    opnd_d     = opnd_q;
    is_div_d   = is_div_q;
    sa_d       = sa_q;
    sb_d       = sb_q;
    dz_pend_d  = dz_pend_q;

    case (state_q)
      IDLE: begin
        if (bus.hi_we) hi_d = bus.wdata;
        if (bus.lo_we) lo_d = bus.wdata;
      end
      CALC: begin
        if (is_div_q) begin
          rem_d = q_bit ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
          acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], q_bit};
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = FINISH;
        end
      end
      FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
        if (is_div_q) begin
          hi_d       = rem_res;
          lo_d       = quo_res;
          div_zero_d = dz_pend_q;
        end else begin
          {hi_d, lo_d} = prod_res;
          div_zero_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      state_d   = CALC;
      busy_d    = 1'b1;
      cnt_d     = '0;
      is_div_d  = op_div;
      sa_d      = a_neg;
      sb_d      = b_neg;
      dz_pend_d = op_div & (bus.b == '0);
      rem_d     = '0;
      if (state_q == IDLE) div_zero_d = 1'b0;
      if (op_div) begin
        acc_d  = {{WIDTH{1'b0}}, a_abs};
        opnd_d = b_abs;
      end else begin
        acc_d  = {{WIDTH{1'b0}}, b_abs};
        opnd_d = a_abs;
      end
    end
  end

  // State registers; reset aborts any operation without a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      div_zero_q <= 1'b0;
      acc_q      <= '0;
      rem_q      <= '0;
      opnd_q     <= '0;
      is_div_q   <= 1'b0;
      sa_q       <= 1'b0;
      sb_q       <= 1'b0;
      dz_pend_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      div_zero_q <= div_zero_d;
      acc_q      <= acc_d;
      rem_q      <= rem_d;
      opnd_q     <= opnd_d;
      is_div_q   <= is_div_d;
      sa_q       <= sa_d;
      sb_q       <= sb_d;
      dz_pend_q  <= dz_pend_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.div_zero = div_zero_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed cases plus random ops against an arithmetic model.
// Results are expected exactly 33 edges after the accepting edge.
// Outputs are sampled 1 time unit after the rising edge; inputs change on the falling edge.
module tb_mul_div_unit;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  mul_div_if #(.WIDTH(32)) bus ();

  mul_div_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic. SV / and % truncate toward zero and the remainder
  // follows the dividend, which is the MIPS rule; the overflow case falls out naturally.
  task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] hi, output logic [31:0] lo, output logic dz);
    longint sa, sb, p, q, r;
    logic [63:0] pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dz = 1'b0;
    hi = '0;
    lo = '0;
    case (op)
      OP_MULT: begin
        p = sa * sb;
        {hi, lo} = p;
      end
      OP_MULTU: begin
        pu = {32'b0, a} * {32'b0, b};
        {hi, lo} = pu;
      end
      default: begin
        if (b == 32'd0) begin
          lo = 32'hFFFF_FFFF;
          hi = a;
          dz = 1'b1;
        end else if (op == OP_DIV) begin
          q  = sa / sb;
          r  = sa % sb;
          lo = q[31:0];
          hi = r[31:0];
        end else begin
          lo = a / b;
          hi = a % b;
        end
      end
    endcase
  endtask

  task automatic drive_start(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
  endtask

  // Drops start and scrambles the operands so a design that re-reads them is caught.
  task automatic scramble;
    bus.start = 1'b0;
    bus.op    = 2'($urandom);
    bus.a     = $urandom;
    bus.b     = $urandom;
  endtask

  // Runs one op to completion. prestarted: already accepted on the previous edge.
  // disturb: pulse hi_we and start mid-op. chain: issue the next op on the done edge.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit prestarted, input bit disturb,
                        input bit chain, input logic [1:0] nop, input logic [31:0] na,
                        input logic [31:0] nb);
    logic [31:0] ehi, elo, hi0;
    logic        edz;
    int          bad;
    model(op, a, b, ehi, elo, edz);
    hi0 = bus.hi;
    if (!prestarted) begin
      @(negedge clk);
      drive_start(op, a, b);
      @(posedge clk);
      #1;
      scramble();
    end
    check({tag, ".busy_on"}, bus.busy, 1'b1);
    bad = 0;
    for (int i = 1; i <= 32; i++) begin
      if (disturb && i == 10) begin
        @(negedge clk);
        bus.hi_we = 1'b1;
        bus.wdata = $urandom;
        bus.start = 1'b1;
      end
      @(posedge clk);
      #1;
      if (disturb && i == 10) begin
        bus.hi_we = 1'b0;
        bus.start = 1'b0;
        check({tag, ".hi_hold"}, bus.hi, hi0);
      end
      if (bus.done || !bus.busy) bad++;
    end
    check({tag, ".early"}, bad, 0);
    @(negedge clk);
    if (chain) drive_start(nop, na, nb);
    @(posedge clk);
    #1;
    if (chain) scramble();
    check({tag, ".done"}, bus.done, 1'b1);
    if (!chain) check({tag, ".busy_off"}, bus.busy, 1'b0);
    check({tag, ".hi"}, bus.hi, ehi);
    check({tag, ".lo"}, bus.lo, elo);
    check({tag, ".dz"}, bus.div_zero, edz);
  endtask

  task automatic op1(input string tag, input logic [1:0] op, input logic [31:0] a,
                     input logic [31:0] b);
    run_op(tag, op, a, b, 1'b0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".busy"}, bus.busy, 1'b0);
    check({tag, ".done"}, bus.done, 1'b0);
    check({tag, ".hi"}, bus.hi, 32'd0);
    check({tag, ".lo"}, bus.lo, 32'd0);
    check({tag, ".dz"}, bus.div_zero, 1'b0);
  endtask

  initial begin
    int          seen;
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = '0;
    bus.b     = '0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.wdata = '0;
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    op1("mult_neg",   OP_MULT,  32'hFFFF_FFFD, 32'h0000_0005);
    @(posedge clk);
    #1;
    check("done_pulse_width", bus.done, 1'b0);
    op1("multu_max",  OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    op1("mult_m1m1",  OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF);
    op1("div_m7_2",   OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002);
    op1("divu_m7_2",  OP_DIVU,  32'hFFFF_FFF9, 32'h0000_0002);
    op1("divu_by0",   OP_DIVU,  32'h0000_0007, 32'h0000_0000);
    op1("div_ovf",    OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
    op1("div_by0_sg", OP_DIV,   32'h8765_4321, 32'h0000_0000);
    op1("mult_minneg", OP_MULT, 32'h8000_0000, 32'h8000_0000);

    // MTHI / MTLO in IDLE, separately and together.
    @(negedge clk);
    bus.lo_we = 1'b1;
    bus.hi_we = 1'b1;
    bus.wdata = 32'hA5A5_5A5A;
    @(posedge clk);
    #1;
    bus.lo_we = 1'b0;
    bus.hi_we = 1'b0;
    check("mt_both.hi", bus.hi, 32'hA5A5_5A5A);
    check("mt_both.lo", bus.lo, 32'hA5A5_5A5A);
    @(negedge clk);
    bus.hi_we = 1'b1;
    bus.wdata = 32'h1234_5678;
    @(posedge clk);
    #1;
    bus.hi_we = 1'b0;
    check("mthi.hi", bus.hi, 32'h1234_5678);
    check("mthi.lo", bus.lo, 32'hA5A5_5A5A);

    // Mid-op hi_we and start are ignored; then a chained op on the done edge.
    run_op("div_disturb", OP_DIV, 32'h0000_1000, 32'hFFFF_FFFD, 1'b0, 1'b1, 1'b1,
           OP_MULTU, 32'h0001_0001, 32'h0000_FFFF);
    run_op("chained", OP_MULTU, 32'h0001_0001, 32'h0000_FFFF, 1'b1, 1'b0, 1'b0,
           2'b00, 32'd0, 32'd0);

    // Random ops, with a bias toward zero and small divisors.
    for (int n = 0; n < 24; n++) begin
      rop = 2'($urandom);
      ra  = $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 9));
        2:       rb = -32'($urandom_range(1, 9));
        default: rb = $urandom;
      endcase
      op1("rand", rop, ra, rb);
    end

    // Asynchronous reset ten cycles into a MULT.
    @(negedge clk);
    drive_start(OP_MULT, 32'h0000_0123, 32'h0000_0456);
    @(posedge clk);
    #1;
    scramble();
    repeat (9) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_reset_outputs("abort");
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) seen++;
    end
    check("abort.no_done", seen, 0);
    op1("after_rst", OP_MULTU, 32'h0000_0003, 32'h0000_0004);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Multi-cycle integer multiply/divide unit that owns the architectural HI/LO register pair for the unicycle MIPS datapath. It replaces single-cycle `{HI,LO}` arithmetic with an iterative shift-add multiplier and a restoring divider, both parametrised in width, with signed and unsigned modes. It adds a start/busy/done handshake and direct HI/LO writes for MTHI/MTLO. It sits beside the ALU; the control unit stalls the pipeline while `busy` is high.

## Interface
- `WIDTH`, default 32: operand width; HI and LO are each `WIDTH` bits.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset; asynchronous, active-high.
- `start` in 1: request an operation; sampled only in IDLE.
- `op` in 2: operation select. 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- `a` in WIDTH: multiplicand or dividend.
- `b` in WIDTH: multiplier or divisor.
- `hi_we` in 1: MTHI write enable.
- `lo_we` in 1: MTLO write enable.
- `wdata` in WIDTH: data for MTHI/MTLO.
- `busy` out 1: operation in progress.
- `done` out 1: one-cycle completion pulse.
- `hi` out WIDTH: HI register. Holds the product high half, or the remainder.
- `lo` out WIDTH: LO register. Holds the product low half, or the quotient.
- `div_zero` out 1: the last completed division had divisor 0.

## Operation
- FSM states and transitions:
  - IDLE: `start` → CALC.
  - CALC: iteration counter runs 0..WIDTH-1. After the last iteration → FINISH.
  - FINISH: → IDLE.
- Operand latch on the accepting edge:
  - `a` and `b` are latched; later input changes are ignored.
  - Signed ops latch absolute values plus the sign bits sA and sB. Unsigned ops treat sign bits as 0.
  - `div_zero` is cleared.
- Multiply, one bit per CALC cycle:
  - Shift-add over a 2·WIDTH accumulator.
  - FINISH negates the 2·WIDTH product if sA^sB.
- Divide, one quotient bit per CALC cycle:
  - Restoring algorithm using a WIDTH+1-bit partial remainder.
  - FINISH negates the quotient if sA^sB and the remainder if sA.
  - The remainder sign always follows the dividend.
- Divisor zero (detected at latch):
  - CALC still runs full length.
  - FINISH writes LO = all ones and HI = original `a` (unsigned view), and sets `div_zero`=1.
- Signed overflow (`a`=most-negative, `b`=-1) gives LO = most-negative, HI = 0, `div_zero`=0, with no trap.
- Results go to HI/LO only in FINISH. HI/LO hold their values at all other times.
- MTHI/MTLO:
  - In IDLE, `hi_we`/`lo_we` write `wdata` on the edge.
  - Both enables may be asserted together.
  - While `busy`=1 they are ignored.
- In IDLE with `start` and a write enable on the same edge, both take effect. The write lands now and the operation overwrites HI/LO at FINISH.
- `start` is ignored while `busy`=1; there is no queueing.
- `op` values are decoded only at the accepting edge.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, `div_zero`=0, counter 0.
- `rst` asserted mid-operation aborts immediately. Outputs take reset values and no `done` is emitted.
- Let edge E be the edge that samples `start`=1 in IDLE:
  - `busy`=1 from E until the FINISH edge E+WIDTH+1.
  - At edge E+WIDTH+1, `hi`, `lo` and `div_zero` update, `done` goes to 1 and `busy` goes to 0.
  - `done` is high for exactly one cycle.
- Result latency: WIDTH+1 cycles (33 at default). This is the same for all ops and data-independent.
- The earliest next `start` is sampled at edge E+WIDTH+1, i.e. back-to-back with `done`. An op accepted there completes at E+2·WIDTH+2.
- The `hi`/`lo` outputs are registers only, with no combinational path from the inputs. The ALU reads them for MFHI/MFLO.

## Test plan
- Reset, then MULT `a`=FFFFFFFD (−3), `b`=00000005 → after 33 cycles `done` pulse, HI=FFFFFFFF, LO=FFFFFFF1, `busy` low in the same cycle.
- MULTU FFFFFFFF×FFFFFFFF → HI=FFFFFFFE, LO=00000001. MULT of the same operands → HI=00000000, LO=00000001.
- DIV −7/2 (FFFFFFF9, 00000002) → LO=FFFFFFFD, HI=FFFFFFFF. DIVU with the same operands → LO=7FFFFFFC, HI=00000001.
- DIVU 7/0 → LO=FFFFFFFF, HI=00000007, `div_zero`=1. The next op clears `div_zero`. DIV 80000000/FFFFFFFF → LO=80000000, HI=0, `div_zero`=0.
- Handshake and writes:
  - MTHI 12345678 in IDLE, then DIV with `hi_we` pulsed mid-op and `start` re-pulsed mid-op → both ignored, and one `done` at +33.
  - After `done`, `start` back-to-back → second result at +33.
- Assert `rst` at cycle 10 of a MULT → all outputs 0 at once, no `done`. After release, a new MULTU 3×4 → LO=0000000C, HI=0.
